// File: rtl/opr_sequencer.sv
// opr_sequencer: multi-cycle controller for PDP-8 operate (opcode 7) instructions.
// Latency: done pulses 3 cycles after start; back-to-back throughput is 4 cycles.
// Backpressure: start is only accepted in IDLE; a start while busy (incl. HALTED) is dropped.
//
// Drives IR[8:0], AC and L to an external combinational micro-instruction decoder
// and captures its results. Applies the group-2 extras (post-skip CLA, OSR, HLT),
// advances the PC on a taken skip and owns the halt state.
//
// Optional feature: define MICRO_SKIP_COUNT_EN to build a saturating counter of
// taken group-2 skips on skip_count_o; otherwise skip_count_o is tied to zero.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             1-cycle request, sampled only in IDLE
//   ir_i, ac_in_i,      instruction word, accumulator, link,
//   l_in_i, pc_in_i     PC (already pointing to the next instruction)
//   sr_i                front-panel switch register (OSR source)
//   resume_i            leave HALTED
//   dec_ireg_o,         registered IR[8:0], AC and L driven to the decoder
//   dec_ac_o, dec_l_o
//   dec_ac_res_i,       decoder results: AC, L, skip, group flags
//   dec_l_res_i, dec_skip_i, dec_g1_i, dec_g2_i, dec_g3_i
//   busy_o              state != IDLE
//   done_o              1-cycle pulse, results valid while high
//   ac_out_o, l_out_o,  committed AC, L, PC (held until the next EVAL)
//   pc_out_o
//   halt_o              high while HALTED
//   illegal_o           non-OPR opcode, group 3 or no group recognised
//   skip_count_o        taken-skip counter (optional feature)

module opr_sequencer #(
  parameter int PC_WIDTH  = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [11:0]          ir_i,
  input  logic [11:0]          ac_in_i,
  input  logic                 l_in_i,
  input  logic [PC_WIDTH-1:0]  pc_in_i,
  input  logic [11:0]          sr_i,
  input  logic                 resume_i,
  output logic [8:0]           dec_ireg_o,
  output logic [11:0]          dec_ac_o,
  output logic                 dec_l_o,
  input  logic [11:0]          dec_ac_res_i,
  input  logic                 dec_l_res_i,
  input  logic                 dec_skip_i,
  input  logic                 dec_g1_i,
  input  logic                 dec_g2_i,
  input  logic                 dec_g3_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [11:0]          ac_out_o,
  output logic                 l_out_o,
  output logic [PC_WIDTH-1:0]  pc_out_o,
  output logic                 halt_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] skip_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_EVAL   = 3'd2,
    S_COMMIT = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Only the IR fields the sequencer itself interprets are kept; the rest of
  // IR[8:0] lives in dec_ireg_q for the decoder.
  logic [2:0]          opc_q, opc_d;
  logic                cla_q, cla_d;   // IR[7]: CLA, applied after the skip test
  logic                osr_q, osr_d;   // IR[2]: OR switch register into AC
  logic                hlt_q, hlt_d;   // IR[1]: halt after commit

  logic [11:0]         ac_lat_q, ac_lat_d;
  logic                l_lat_q, l_lat_d;
  logic [PC_WIDTH-1:0] pc_lat_q, pc_lat_d;
  logic [11:0]         sr_lat_q, sr_lat_d;

  logic [8:0]          dec_ireg_q, dec_ireg_d;
  logic [11:0]         dec_ac_q, dec_ac_d;
  logic                dec_l_q, dec_l_d;

  logic [11:0]         res_ac_q, res_ac_d;
  logic                res_l_q, res_l_d;
  logic                res_skip_q, res_skip_d;
  logic                g1_q, g1_d;
  logic                g2_q, g2_d;
  logic                g3_q, g3_d;

  logic [11:0]         ac_out_q, ac_out_d;
  logic                l_out_q, l_out_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                illegal_q, illegal_d;
  logic                halt_q, halt_d;

  logic                eval_illegal;
  logic [11:0]         g2_a0;
  logic                halt_go;

  // A word that is not opcode 7, is group 3, or that the decoder failed to
  // classify at all is reported illegal and passes its inputs through.
  assign eval_illegal = (opc_q != 3'o7) || g3_q || !(g1_q || g2_q);

  // Group-2 CLA happens after the skip test, so the skip came from the pre-CLA AC.
  assign g2_a0   = cla_q ? 12'o0000 : ac_lat_q;
  assign halt_go = g2_q && hlt_q && !illegal_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_EVAL;
      S_EVAL:   state_d = S_COMMIT;
      S_COMMIT: state_d = halt_go ? S_HALTED : S_IDLE;
      S_HALTED: if (resume_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    opc_d      = opc_q;
    cla_d      = cla_q;
    osr_d      = osr_q;
    hlt_d      = hlt_q;
    ac_lat_d   = ac_lat_q;
    l_lat_d    = l_lat_q;
    pc_lat_d   = pc_lat_q;
    sr_lat_d   = sr_lat_q;
    dec_ireg_d = dec_ireg_q;
    dec_ac_d   = dec_ac_q;
    dec_l_d    = dec_l_q;
    res_ac_d   = res_ac_q;
    res_l_d    = res_l_q;
    res_skip_d = res_skip_q;
    g1_d       = g1_q;
    g2_d       = g2_q;
    g3_d       = g3_q;
    ac_out_d   = ac_out_q;
    l_out_d    = l_out_q;
    pc_out_d   = pc_out_q;
    illegal_d  = illegal_q;
    halt_d     = halt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          opc_d      = ir_i[11:9];
          cla_d      = ir_i[7];
          osr_d      = ir_i[2];
          hlt_d      = ir_i[1];
          ac_lat_d   = ac_in_i;
          l_lat_d    = l_in_i;
          pc_lat_d   = pc_in_i;
          sr_lat_d   = sr_i;
          dec_ireg_d = ir_i[8:0];
          dec_ac_d   = ac_in_i;
          dec_l_d    = l_in_i;
        end
      end

      S_ISSUE: begin
        // Decoder inputs have been stable for a full cycle here.
        res_ac_d   = dec_ac_res_i;
        res_l_d    = dec_l_res_i;
        res_skip_d = dec_skip_i;
        g1_d       = dec_g1_i;
        g2_d       = dec_g2_i;
        g3_d       = dec_g3_i;
      end

      S_EVAL: begin
        illegal_d = eval_illegal;
        if (eval_illegal) begin
          ac_out_d = ac_lat_q;
          l_out_d  = l_lat_q;
          pc_out_d = pc_lat_q;
        end else if (g1_q) begin
          ac_out_d = res_ac_q;
          l_out_d  = res_l_q;
          pc_out_d = pc_lat_q;
        end else begin
          ac_out_d = osr_q ? (g2_a0 | sr_lat_q) : g2_a0;
          l_out_d  = l_lat_q;
          // Wraps modulo 2**PC_WIDTH.
          pc_out_d = pc_lat_q + PC_WIDTH'(res_skip_q);
        end
      end

      S_COMMIT: begin
        if (halt_go) halt_d = 1'b1;
      end

      S_HALTED: begin
        if (resume_i) halt_d = 1'b0;
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opc_q      <= 3'o0;
      cla_q      <= 1'b0;
      osr_q      <= 1'b0;
      hlt_q      <= 1'b0;
      ac_lat_q   <= 12'o0000;
      l_lat_q    <= 1'b0;
      pc_lat_q   <= '0;
      sr_lat_q   <= 12'o0000;
      dec_ireg_q <= 9'o000;
      dec_ac_q   <= 12'o0000;
      dec_l_q    <= 1'b0;
      res_ac_q   <= 12'o0000;
      res_l_q    <= 1'b0;
      res_skip_q <= 1'b0;
      g1_q       <= 1'b0;
      g2_q       <= 1'b0;
      g3_q       <= 1'b0;
      ac_out_q   <= 12'o0000;
      l_out_q    <= 1'b0;
      pc_out_q   <= '0;
      illegal_q  <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      opc_q      <= opc_d;
      cla_q      <= cla_d;
      osr_q      <= osr_d;
      hlt_q      <= hlt_d;
      ac_lat_q   <= ac_lat_d;
      l_lat_q    <= l_lat_d;
      pc_lat_q   <= pc_lat_d;
      sr_lat_q   <= sr_lat_d;
      dec_ireg_q <= dec_ireg_d;
      dec_ac_q   <= dec_ac_d;
      dec_l_q    <= dec_l_d;
      res_ac_q   <= res_ac_d;
      res_l_q    <= res_l_d;
      res_skip_q <= res_skip_d;
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      g3_q       <= g3_d;
      ac_out_q   <= ac_out_d;
      l_out_q    <= l_out_d;
      pc_out_q   <= pc_out_d;
      illegal_q  <= illegal_d;
      halt_q     <= halt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional taken-skip counter
  // ---------------------------------------------------------------------------
`ifdef MICRO_SKIP_COUNT_EN
  logic [CNT_WIDTH-1:0] skip_cnt_q, skip_cnt_d;

  always_comb begin
    skip_cnt_d = skip_cnt_q;
    // Saturates at all-ones rather than wrapping.
    if ((state_q == S_EVAL) && g2_q && res_skip_q && !eval_illegal &&
        (skip_cnt_q != {CNT_WIDTH{1'b1}})) begin
      skip_cnt_d = skip_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skip_cnt_q <= '0;
    end else begin
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign skip_count_o = skip_cnt_q;
`else
  assign skip_count_o = {CNT_WIDTH{1'b0}};
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dec_ireg_o = dec_ireg_q;
  assign dec_ac_o   = dec_ac_q;
  assign dec_l_o    = dec_l_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_COMMIT);
  assign ac_out_o   = ac_out_q;
  assign l_out_o    = l_out_q;
  assign pc_out_o   = pc_out_q;
  assign halt_o     = halt_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_opr_sequencer.sv
// Directed bench for opr_sequencer with a behavioural PDP-8 micro-instruction
// decoder standing in for the real combinational decoder.
module tb_opr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] ir;
  logic [11:0] ac_in;
  logic        l_in;
  logic [11:0] pc_in;
  logic [11:0] sr;
  logic        resume;
  logic [8:0]  dec_ireg;
  logic [11:0] dec_ac;
  logic        dec_l;
  logic [11:0] dec_ac_res;
  logic        dec_l_res;
  logic        dec_skip;
  logic        dec_g1, dec_g2, dec_g3;
  logic        busy, done;
  logic [11:0] ac_out;
  logic        l_out;
  logic [11:0] pc_out;
  logic        halt, illegal;
  logic [15:0] skip_count;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MICRO_SKIP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  opr_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .ir_i         (ir),
    .ac_in_i      (ac_in),
    .l_in_i       (l_in),
    .pc_in_i      (pc_in),
    .sr_i         (sr),
    .resume_i     (resume),
    .dec_ireg_o   (dec_ireg),
    .dec_ac_o     (dec_ac),
    .dec_l_o      (dec_l),
    .dec_ac_res_i (dec_ac_res),
    .dec_l_res_i  (dec_l_res),
    .dec_skip_i   (dec_skip),
    .dec_g1_i     (dec_g1),
    .dec_g2_i     (dec_g2),
    .dec_g3_i     (dec_g3),
    .busy_o       (busy),
    .done_o       (done),
    .ac_out_o     (ac_out),
    .l_out_o      (l_out),
    .pc_out_o     (pc_out),
    .halt_o       (halt),
    .illegal_o    (illegal),
    .skip_count_o (skip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural decoder: group 1 (CLA CLL / CMA CML / IAC / rotates) and
  // group-2 skip evaluation; group-2 AC is passed through unchanged.
  logic [11:0] m_ac;
  logic        m_l;
  always_comb begin
    m_ac     = dec_ac;
    m_l      = dec_l;
    dec_g1   = !dec_ireg[8];
    dec_g2   = dec_ireg[8] && !dec_ireg[0];
    dec_g3   = dec_ireg[8] && dec_ireg[0];
    dec_skip = 1'b0;
    if (dec_g1) begin
      if (dec_ireg[7]) m_ac = 12'o0000;
      if (dec_ireg[6]) m_l  = 1'b0;
      if (dec_ireg[5]) m_ac = ~m_ac;
      if (dec_ireg[4]) m_l  = ~m_l;
      if (dec_ireg[0]) {m_l, m_ac} = {m_l, m_ac} + 13'd1;
      if (dec_ireg[3]) {m_l, m_ac} = {m_ac[0], m_l, m_ac[11:1]};
      if (dec_ireg[2]) {m_l, m_ac} = {m_ac, m_l};
    end else if (dec_g2) begin
      dec_skip = ((dec_ireg[6] && m_ac[11]) || (dec_ireg[5] && (m_ac == 12'o0000)) ||
                  (dec_ireg[4] && m_l)) ^ dec_ireg[3];
    end
    dec_ac_res = m_ac;
    dec_l_res  = m_l;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and step to its COMMIT cycle, checking the 3-cycle latency.
  task automatic run_op(input string tag, input logic [11:0] i_ir, input logic [11:0] i_ac,
                        input logic i_l, input logic [11:0] i_pc, input logic [11:0] i_sr);
    ir = i_ir; ac_in = i_ac; l_in = i_l; pc_in = i_pc; sr = i_sr;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_issue"}, busy, 1);
    chk({tag, "_done_issue"}, done, 0);
    tick();
    chk({tag, "_done_eval"}, done, 0);
    tick();
    chk({tag, "_done_commit"}, done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; resume = 1'b0;
    ir = '0; ac_in = '0; l_in = 1'b0; pc_in = '0; sr = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_halt", halt, 0);
    chk("rst_ac", ac_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_ireg", dec_ireg, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_skipcnt", skip_count, 0);
    rst = 1'b0;
    tick();

    // CLA CLL
    run_op("cla_cll", 12'o7300, 12'o1234, 1'b1, 12'o0100, 12'o0000);
    chk("cla_cll_ac", ac_out, 12'o0000);
    chk("cla_cll_l", l_out, 0);
    chk("cla_cll_pc", pc_out, 12'o0100);
    chk("cla_cll_illegal", illegal, 0);
    tick();
    chk("cla_cll_idle", busy, 0);
    chk("cla_cll_done_low", done, 0);

    // IAC
    run_op("iac", 12'o7001, 12'o0005, 1'b0, 12'o0100, 12'o0000);
    chk("iac_ac", ac_out, 12'o0006);
    chk("iac_l", l_out, 0);
    chk("iac_illegal", illegal, 0);
    tick();

    // SNA taken, not taken, PC wrap
    run_op("sna_t", 12'o7450, 12'o0001, 1'b0, 12'o0200, 12'o0000);
    chk("sna_t_pc", pc_out, 12'o0201);
    chk("sna_t_ac", ac_out, 12'o0001);
    chk("sna_t_cnt", skip_count, CNT_EN ? 1 : 0);
    tick();
    run_op("sna_n", 12'o7450, 12'o0000, 1'b1, 12'o0200, 12'o0000);
    chk("sna_n_pc", pc_out, 12'o0200);
    chk("sna_n_l", l_out, 1);
    chk("sna_n_cnt", skip_count, CNT_EN ? 1 : 0);
    tick();
    run_op("sna_w", 12'o7450, 12'o0001, 1'b0, 12'o7777, 12'o0000);
    chk("sna_w_pc", pc_out, 12'o0000);
    chk("sna_w_cnt", skip_count, CNT_EN ? 2 : 0);
    tick();

    // CLA OSR
    run_op("osr", 12'o7604, 12'o1111, 1'b0, 12'o0300, 12'o5252);
    chk("osr_ac", ac_out, 12'o5252);
    chk("osr_pc", pc_out, 12'o0300);
    tick();

    // HLT, start ignored while halted, resume
    run_op("hlt", 12'o7402, 12'o0017, 1'b0, 12'o0400, 12'o0000);
    chk("hlt_ac", ac_out, 12'o0017);
    chk("hlt_halt_commit", halt, 0);
    tick();
    chk("hlt_halt", halt, 1);
    chk("hlt_busy", busy, 1);
    ir = 12'o7001; start = 1'b1;
    tick();
    start = 1'b0;
    chk("hlt_start_halt", halt, 1);
    chk("hlt_start_done", done, 0);
    chk("hlt_start_ireg", dec_ireg, 9'o402);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_busy", busy, 0);
    chk("resume_halt", halt, 0);

    // Non-OPR opcode and group 3
    run_op("tad", 12'o1234, 12'o0777, 1'b1, 12'o0300, 12'o0000);
    chk("tad_illegal", illegal, 1);
    chk("tad_ac", ac_out, 12'o0777);
    chk("tad_l", l_out, 1);
    chk("tad_pc", pc_out, 12'o0300);
    tick();
    chk("tad_no_halt", halt, 0);
    run_op("g3", 12'o7401, 12'o0042, 1'b0, 12'o0500, 12'o0000);
    chk("g3_illegal", illegal, 1);
    chk("g3_ac", ac_out, 12'o0042);
    tick();

    // Start during EVAL is dropped
    ir = 12'o7001; ac_in = 12'o0005; l_in = 1'b0; pc_in = 12'o0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ir = 12'o7300; ac_in = 12'o1234; start = 1'b1;
    tick();
    start = 1'b0;
    chk("evalstart_done", done, 1);
    chk("evalstart_ac", ac_out, 12'o0006);
    chk("evalstart_illegal", illegal, 0);
    tick();
    chk("evalstart_idle", busy, 0);
    tick();
    chk("evalstart_still_idle", busy, 0);
    chk("evalstart_ireg", dec_ireg, 9'o001);

    // Reset while in ISSUE
    ir = 12'o7001; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rstissue_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstissue_busy", busy, 0);
    chk("rstissue_done", done, 0);
    chk("rstissue_ac", ac_out, 0);
    chk("rstissue_cnt", skip_count, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstissue_done_later", done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
